// File: rtl/mem_arbiter_ctrl_if.sv
// Client-side request/response bundle for mem_arbiter_ctrl: one lane per requester channel.
interface mem_arbiter_ctrl_if #(
    parameter int NUM_CH = 3
);
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        wr;
    logic [NUM_CH-1:0][31:0]  addr;
    logic [NUM_CH-1:0][31:0]  wdata;
    logic [NUM_CH-1:0][1:0]   size;
    logic [NUM_CH-1:0]        flush;
    logic [NUM_CH-1:0]        done;
    logic [31:0]              rdata;

    modport master (output req, wr, addr, wdata, size, flush, input done, rdata);
    modport slave  (input req, wr, addr, wdata, size, flush, output done, rdata);
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Round-robin arbiter of NUM_CH clients onto a byte-serial RAM/IO bus with 1/2/4-byte
// little-endian transactions, read flush on rollback and IO write stalling.
module mem_arbiter_ctrl #(
    parameter int         NUM_CH = 3,
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    mem_arbiter_ctrl_if.slave    bus,
    input  logic                 io_buffer_full,
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [31:0]          mem_a,
    output logic                 mem_wr
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, IO_WAIT} state_t;

    state_t              state;
    logic [CW-1:0]       ch;
    logic [CW-1:0]       rr;
    logic [31:0]         base;
    logic [31:0]         wbuf;
    logic [31:0]         rbuf;
    logic [2:0]          nbytes;
    logic [2:0]          cnt;
    logic [NUM_CH-1:0]   done_q;
    logic [31:0]         rdata_q;
    logic [31:0]         mem_a_q;
    logic [7:0]          mem_dout_q;
    logic                mem_wr_q;

    // Arbitration: a read whose channel is flushing this cycle is not a candidate.
    logic [NUM_CH-1:0]   cand;
    logic                grant_vld;
    logic [CW-1:0]       grant;
    always_comb begin
        int j;
        cand      = bus.req & ~(bus.flush & ~bus.wr);
        grant_vld = 1'b0;
        grant     = '0;
        j         = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = int'(rr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (cand[j]) begin
                grant_vld = 1'b1;
                grant     = CW'(j);
            end
        end
    end

    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic        g_wr;
    logic [2:0]  g_nb;
    logic        g_io;
    always_comb begin
        g_addr  = bus.addr[grant];
        g_wdata = bus.wdata[grant];
        g_wr    = bus.wr[grant];
        case (bus.size[grant])
            2'd0:    g_nb = 3'd1;
            2'd1:    g_nb = 3'd2;
            default: g_nb = 3'd4;
        endcase
        g_io = (g_addr[17:16] == IO_SEL);
    end

    // Read assembly: byte cnt-1 arrives on mem_din in the current cycle.
    logic [1:0]  ridx;
    logic [31:0] rcur;
    always_comb begin
        ridx = cnt[1:0] - 2'd1;
        rcur = rbuf;
        rcur[8*ridx +: 8] = mem_din;
    end

    // Next write byte: IO_WAIT re-issues the stalled byte, WRITE advances to the following one.
    logic [1:0]  widx;
    logic [31:0] wnext_a;
    logic [7:0]  wnext_d;
    logic        io_hit;
    always_comb begin
        widx    = (state == IO_WAIT) ? cnt[1:0] : cnt[1:0] + 2'd1;
        wnext_a = base + {30'b0, widx};
        wnext_d = wbuf[8*widx +: 8];
        io_hit  = (base[17:16] == IO_SEL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ch         <= '0;
            rr         <= '0;
            base       <= '0;
            wbuf       <= '0;
            rbuf       <= '0;
            nbytes     <= 3'd1;
            cnt        <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
        end else if (rdy) begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    mem_a_q  <= '0;
                    mem_wr_q <= 1'b0;
                    if (grant_vld) begin
                        ch     <= grant;
                        base   <= g_addr;
                        wbuf   <= g_wdata;
                        nbytes <= g_nb;
                        cnt    <= '0;
                        rbuf   <= '0;
                        rr     <= (int'(grant) == NUM_CH - 1) ? '0 : grant + CW'(1);
                        if (!g_wr) begin
                            state   <= READ;
                            mem_a_q <= g_addr;
                        end else if (g_io && io_buffer_full) begin
                            state <= IO_WAIT;
                        end else begin
                            state      <= WRITE;
                            mem_a_q    <= g_addr;
                            mem_dout_q <= g_wdata[7:0];
                            mem_wr_q   <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (bus.flush[ch]) begin
                        state   <= IDLE;
                        mem_a_q <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt + 3'd1 < nbytes) mem_a_q <= base + 32'(cnt) + 32'd1;
                        else                     mem_a_q <= '0;
                        if (cnt != 3'd0) rbuf <= rcur;
                        if (cnt == nbytes) begin
                            done_q[ch] <= 1'b1;
                            rdata_q    <= rcur;
                            state      <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (cnt + 3'd1 == nbytes) begin
                        done_q[ch] <= 1'b1;
                        mem_wr_q   <= 1'b0;
                        mem_a_q    <= '0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (io_hit && io_buffer_full) begin
                            state    <= IO_WAIT;
                            mem_wr_q <= 1'b0;
                            mem_a_q  <= '0;
                        end else begin
                            mem_a_q    <= wnext_a;
                            mem_dout_q <= wnext_d;
                            mem_wr_q   <= 1'b1;
                        end
                    end
                end
                IO_WAIT: begin
                    if (!io_buffer_full) begin
                        state      <= WRITE;
                        mem_a_q    <= wnext_a;
                        mem_dout_q <= wnext_d;
                        mem_wr_q   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    // A paused RAM must not see a write strobe.
    assign mem_wr    = mem_wr_q & rdy;
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl: vector table of single transactions plus hand sequences.
module tb_mem_arbiter_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_arbiter_ctrl_if #(.NUM_CH(3)) bus ();

    mem_arbiter_ctrl #(.NUM_CH(3), .IO_SEL(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .bus(bus),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    // RAM model: 4K bytes indexed by {addr[17:16], addr[9:0]}, paused while rdy is low.
    logic [7:0] ram [0:4095];
    function automatic int ri(input logic [31:0] a);
        return int'({20'b0, a[17:16], a[9:0]});
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            ram[12'h100] <= 8'h11;
            ram[12'h101] <= 8'h22;
            ram[12'h102] <= 8'h33;
            ram[12'h103] <= 8'h44;
            ram[12'h322] <= 8'h00;
            ram[12'h323] <= 8'h00;
        end else if (rdy) begin
            if (mem_wr) ram[ri(mem_a)] <= mem_dout;
            mem_din <= ram[ri(mem_a)];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          ch;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;
    vec_t tv [10];

    // Issue one transaction with a one-cycle req pulse; returns cycles until done.
    task automatic run_txn(input int ch, input bit wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [2:0] dv, output logic [31:0] rd);
        bus.wr[ch] = wr; bus.size[ch] = size; bus.addr[ch] = addr; bus.wdata[ch] = wdata;
        bus.req[ch] = 1'b1;
        lat = 99; dv = '0; rd = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) bus.req[ch] = 1'b0;
            if (bus.done != 3'b0) begin
                lat = c; dv = bus.done; rd = bus.rdata;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic [2:0]  dv;
        logic [31:0] rd;
        int          nd, wrcnt, wrc, d2cnt, dcyc;
        int          dch [4];
        int          dat [4];
        logic [31:0] drd [4];

        tv[0] = '{1, 1'b1, 2'd1, 32'h0000_0200, 32'h0000_BEEF, 32'h0, 3};
        tv[1] = '{0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h4433_2211, 6};
        tv[2] = '{2, 1'b0, 2'd1, 32'h0000_0200, 32'h0,         32'h0000_BEEF, 4};
        tv[3] = '{0, 1'b0, 2'd0, 32'h0000_0101, 32'h0,         32'h0000_0022, 3};
        tv[4] = '{2, 1'b1, 2'd2, 32'h0000_0040, 32'hA1B2_C3D4, 32'h0, 5};
        tv[5] = '{1, 1'b0, 2'd2, 32'h0000_0040, 32'h0,         32'hA1B2_C3D4, 6};
        tv[6] = '{0, 1'b1, 2'd3, 32'h0000_0080, 32'h0102_0304, 32'h0, 5};
        tv[7] = '{1, 1'b0, 2'd3, 32'h0000_0080, 32'h0,         32'h0102_0304, 6};
        tv[8] = '{0, 1'b1, 2'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0, 5};
        tv[9] = '{2, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'hCAFE_F00D, 6};

        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
        bus.req = '0; bus.wr = '0; bus.addr = '0; bus.wdata = '0; bus.size = '0; bus.flush = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("reset mem_a", mem_a, 32'h0);
        chk("reset done", {29'b0, bus.done}, 32'h0);
        chk("reset rdata", bus.rdata, 32'h0);
        chk("reset mem_dout", {24'b0, mem_dout}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            run_txn(tv[i].ch, tv[i].wr, tv[i].size, tv[i].addr, tv[i].wdata, lat, dv, rd);
            chk($sformatf("vec%0d latency", i), lat, tv[i].exp_lat);
            chk($sformatf("vec%0d done", i), {29'b0, dv}, 32'(1 << tv[i].ch));
            if (!tv[i].wr) chk($sformatf("vec%0d rdata", i), rd, tv[i].exp_rd);
        end

        // All three channels held requesting byte reads: grants 0,1,2,0 back to back.
        for (int k = 0; k < 3; k++) begin
            bus.wr[k] = 1'b0; bus.size[k] = 2'd0; bus.addr[k] = 32'h100 + 32'(k);
        end
        bus.req = 3'b111;
        nd = 0;
        for (int c = 1; c <= 30 && nd < 4; c++) begin
            @(negedge clk);
            if (bus.done != 3'b0) begin
                dch[nd] = (bus.done == 3'b001) ? 0 : (bus.done == 3'b010) ? 1 :
                          (bus.done == 3'b100) ? 2 : 9;
                dat[nd] = c; drd[nd] = bus.rdata;
                nd++;
                if (nd == 4) bus.req = '0;
            end
        end
        bus.req = '0;
        chk("rr done count", nd, 4);
        if (nd == 4) begin
            chk("rr grant0", dch[0], 0);
            chk("rr grant1", dch[1], 1);
            chk("rr grant2", dch[2], 2);
            chk("rr grant3", dch[3], 0);
            chk("rr first latency", dat[0], 3);
            chk("rr gap", dat[3] - dat[0], 9);
            chk("rr rdata1", drd[1], 32'h22);
            chk("rr rdata2", drd[2], 32'h33);
        end
        @(negedge clk);

        // IO write stalled by io_buffer_full for 5 cycles.
        bus.wr[1] = 1'b1; bus.size[1] = 2'd0; bus.addr[1] = 32'h0003_0000; bus.wdata[1] = 32'h41;
        bus.req[1] = 1'b1; io_buffer_full = 1'b1;
        wrcnt = 0; wrc = 0; dcyc = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) bus.req[1] = 1'b0;
            if (mem_wr) begin
                wrcnt++; wrc = c;
                chk("io byte addr", mem_a, 32'h0003_0000);
                chk("io byte data", {24'b0, mem_dout}, 32'h41);
            end
            if (bus.done[1] && dcyc == 0) dcyc = c;
            if (c == 5) io_buffer_full = 1'b0;
        end
        chk("io write count", wrcnt, 1);
        chk("io write cycle", wrc, 6);
        chk("io done cycle", dcyc, 7);
        chk("io ram byte", {24'b0, ram[ri(32'h0003_0000)]}, 32'h41);

        // ch2 word read flushed at T+2 while ch0 waits.
        bus.wr[2] = 1'b0; bus.size[2] = 2'd2; bus.addr[2] = 32'h100;
        bus.wr[0] = 1'b0; bus.size[0] = 2'd0; bus.addr[0] = 32'h101;
        bus.req[2] = 1'b1; bus.req[0] = 1'b1;
        d2cnt = 0; dcyc = 0; rd = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.done[2]) d2cnt++;
            if (bus.done[0] && dcyc == 0) begin dcyc = c; rd = bus.rdata; end
            if (c == 1) bus.req[2] = 1'b0;
            if (c == 2) bus.flush[2] = 1'b1;
            if (c == 3) begin
                bus.flush[2] = 1'b0;
                chk("flush mem_a", mem_a, 32'h0);
                chk("flush mem_wr", {31'b0, mem_wr}, 32'h0);
            end
            if (c == 4) begin
                chk("flush next grant addr", mem_a, 32'h101);
                bus.req[0] = 1'b0;
            end
        end
        chk("flush no done2", d2cnt, 0);
        chk("flush ch0 done cycle", dcyc, 6);
        chk("flush ch0 rdata", rd, 32'h22);

        // Flush asserted on a write channel has no effect.
        bus.flush[2] = 1'b1;
        run_txn(2, 1'b1, 2'd2, 32'h310, 32'h99AA_BBCC, lat, dv, rd);
        bus.flush[2] = 1'b0;
        chk("wflush latency", lat, 5);
        chk("wflush done", {29'b0, dv}, 32'h4);
        chk("wflush ram", {ram[ri(32'h313)], ram[ri(32'h312)], ram[ri(32'h311)], ram[ri(32'h310)]},
            32'h99AA_BBCC);

        // rdy low for 3 cycles in the middle of a word write.
        bus.wr[0] = 1'b1; bus.size[0] = 2'd2; bus.addr[0] = 32'h300; bus.wdata[0] = 32'h5566_7788;
        bus.req[0] = 1'b1;
        dcyc = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) bus.req[0] = 1'b0;
            if (bus.done[0] && dcyc == 0) dcyc = c;
            if (c == 2) rdy = 1'b0;
            if (c == 3) begin
                chk("freeze mem_wr", {31'b0, mem_wr}, 32'h0);
                chk("freeze mem_a", mem_a, 32'h301);
            end
            if (c == 5) rdy = 1'b1;
        end
        chk("freeze done cycle", dcyc, 8);
        chk("freeze ram", {ram[ri(32'h303)], ram[ri(32'h302)], ram[ri(32'h301)], ram[ri(32'h300)]},
            32'h5566_7788);

        // Reset in the middle of a word write abandons it.
        bus.wr[1] = 1'b1; bus.size[1] = 2'd2; bus.addr[1] = 32'h320; bus.wdata[1] = 32'hDEAD_BEEF;
        bus.req[1] = 1'b1;
        d2cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) bus.req[1] = 1'b0;
            if (bus.done != 3'b0) d2cnt++;
            if (c == 2) rst = 1'b1;
            if (c == 3) begin
                rst = 1'b0;
                chk("midrst mem_wr", {31'b0, mem_wr}, 32'h0);
                chk("midrst mem_a", mem_a, 32'h0);
            end
        end
        chk("midrst no done", d2cnt, 0);
        chk("midrst byte2 unwritten", {24'b0, ram[ri(32'h322)]}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
